baud_tick_ctrl: RTL

BAUD_TICK_CTRL -- requirements
Module: baud_tick_ctrl

---
 rtl/baud_tick_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/baud_tick_ctrl.sv
// Baud tick controller: divides clk_in into an oversample strobe (os_tick)
// and a baud strobe (baud_tick, every OSR oversample ticks). A new divisor
// is taken through a valid/ready handshake. While running, a new divisor
// is held pending and swapped in only on a baud boundary, so a baud period
// is never cut short.
module baud_tick_ctrl #(
  parameter int unsigned OSR     = 16,
  parameter logic [15:0] RST_DIV = 16'd53
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        en,
  input  logic        cfg_valid,
  input  logic [15:0] cfg_div,
  output logic        cfg_ready,
  output logic        os_tick,
  output logic        baud_tick,
  output logic [15:0] div_active,
  output logic        running
);

  localparam int unsigned    OSW     = $clog2(OSR);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OSR - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RELOAD
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    div_q, div_d;
  logic [15:0]    pend_q, pend_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [OSW-1:0] os_cnt_q, os_cnt_d;
  logic           ready_q, ready_d;
  logic           os_tick_q, os_tick_d;
  logic           baud_q, baud_d;
  logic           running_q, running_d;

  logic accept;
  logic wrap;
  logic os_last;
  logic boundary;

  assign accept   = cfg_valid && ready_q;
  assign wrap     = (cnt_q == div_q);
  assign os_last  = (os_cnt_q == OS_LAST);
  assign boundary = wrap && os_last;

  // State and datapath registers; reset returns to IDLE with the reset divisor.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= RST_DIV;
      pend_q    <= '0;
      cnt_q     <= '0;
      os_cnt_q  <= '0;
      ready_q   <= 1'b1;
      os_tick_q <= 1'b0;
      baud_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      os_cnt_q  <= os_cnt_d;
      ready_q   <= ready_d;
      os_tick_q <= os_tick_d;
      baud_q    <= baud_d;
      running_q <= running_d;
    end
  end

  // Next-state logic: disable always wins, then handshake / baud boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = en ? RUN : IDLE;
      RUN: begin
        if (!en)         state_d = IDLE;
        else if (accept) state_d = RELOAD;
      end
      RELOAD: begin
        if (!en)           state_d = IDLE;
        else if (boundary) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, divisor handling and registered strobes.
  always_comb begin
    div_d     = div_q;
    pend_d    = pend_q;
    cnt_d     = '0;
    os_cnt_d  = os_cnt_q;
    ready_d   = ready_q;
    os_tick_d = 1'b0;
    baud_d    = 1'b0;
    running_d = (state_d != IDLE);

    case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        ready_d  = 1'b1;
        if (accept) div_d = cfg_div;
      end
      RUN, RELOAD: begin
        if (!en) begin
          os_cnt_d = '0;
          ready_d  = 1'b1;
          if (state_q == RELOAD) begin
            div_d = pend_q;
          end else if (accept) begin
            // Handshake completed while stopping: apply directly, nothing left to defer to.
            div_d = cfg_div;
          end
        end else begin
          if (wrap) begin
            os_tick_d = 1'b1;
            baud_d    = os_last;
            os_cnt_d  = os_last ? '0 : os_cnt_q + OSW'(1);
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
          if (state_q == RUN && accept) begin
            pend_d  = cfg_div;
            ready_d = 1'b0;
          end
          if (state_q == RELOAD && boundary) begin
            // cnt wraps to 0 on this same edge, so the new divisor starts a clean period.
            div_d   = pend_q;
            ready_d = 1'b1;
          end
        end
      end
      default: begin
        os_cnt_d = '0;
        ready_d  = 1'b1;
      end
    endcase
  end

  assign cfg_ready  = ready_q;
  assign os_tick    = os_tick_q;
  assign baud_tick  = baud_q;
  assign div_active = div_q;
  assign running    = running_q;

endmodule
